// File: rtl/cam_table.sv
// Content-addressable match table: DEPTH keys with valid bits, write/invalidate/flush updates,
// and a two-stage search pipeline reporting lowest hit index, multi-hit and a free-slot pointer.
module cam_table #(
    parameter  int DATA_WIDTH = 16,
    parameter  int ADDR_WIDTH = 4,
    localparam int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  inv_en,
    input  logic [ADDR_WIDTH-1:0] inv_addr,
    input  logic                  flush,
    input  logic                  srch_en,
    input  logic [DATA_WIDTH-1:0] srch_key,
    output logic                  srch_valid,
    output logic                  srch_hit,
    output logic [ADDR_WIDTH-1:0] srch_addr,
    output logic                  srch_multi,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] free_addr
);

    // Handshake: every port is a one-cycle request with no back-pressure; srch_valid marks
    // the single cycle in which a search result is presented, two cycles after srch_en.

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_nx;
    logic [DATA_WIDTH-1:0] keys_q [DEPTH];
    logic [ADDR_WIDTH:0]   occ_nx;
    logic [ADDR_WIDTH-1:0] free_nx;
    logic                  free_found;

    logic [DEPTH-1:0]      match_nx;
    logic [DEPTH-1:0]      match_q;
    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] enc_addr;
    logic                  enc_found;

    // Invalidate is applied after the write so it wins on a shared address.
    always_comb begin
        valid_nx = valid_q;
        if (flush) begin
            valid_nx = '0;
        end else begin
            if (wr_en)  valid_nx[wr_addr]  = 1'b1;
            if (inv_en) valid_nx[inv_addr] = 1'b0;
        end
    end

    always_comb begin
        occ_nx     = '0;
        free_nx    = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_nx = occ_nx + {{ADDR_WIDTH{1'b0}}, valid_nx[i]};
            if (!valid_nx[i] && !free_found) begin
                free_nx    = ADDR_WIDTH'(i);
                free_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            free_addr <= '0;
        end else begin
            valid_q   <= valid_nx;
            occupancy <= occ_nx;
            full      <= &valid_nx;
            free_addr <= free_nx;
        end
    end

    // Key storage carries no reset; its contents only matter behind a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) keys_q[wr_addr] <= wr_data;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_nx[i] = valid_q[i] && (keys_q[i] == srch_key);
        end
    end

    always_comb begin
        enc_addr  = '0;
        enc_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match_q[i] && !enc_found) begin
                enc_addr  = ADDR_WIDTH'(i);
                enc_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            match_q    <= '0;
            srch_valid <= 1'b0;
            srch_hit   <= 1'b0;
            srch_addr  <= '0;
            srch_multi <= 1'b0;
        end else begin
            s1_valid   <= srch_en;
            match_q    <= srch_en ? match_nx : '0;
            srch_valid <= s1_valid;
            srch_hit   <= s1_valid && (|match_q);
            srch_addr  <= s1_valid ? enc_addr : '0;
            // Clearing the lowest set bit leaves something only when two or more bits were set.
            srch_multi <= s1_valid && ((match_q & (match_q - 1'b1)) != '0);
        end
    end

endmodule

// File: tb/tb_cam_table.sv
// Directed bench for cam_table: a behavioural table model with a delayed expected queue,
// checked every cycle, plus hand-computed checks following the test plan.
module tb_cam_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        inv_en = 1'b0;
    logic [3:0]  inv_addr = '0;
    logic        flush = 1'b0;
    logic        srch_en = 1'b0;
    logic [15:0] srch_key = '0;
    logic        srch_valid;
    logic        srch_hit;
    logic [3:0]  srch_addr;
    logic        srch_multi;
    logic [4:0]  occupancy;
    logic        full;
    logic [3:0]  free_addr;

    int errors = 0;
    int checks = 0;

    cam_table #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush),
        .srch_en(srch_en), .srch_key(srch_key),
        .srch_valid(srch_valid), .srch_hit(srch_hit), .srch_addr(srch_addr),
        .srch_multi(srch_multi), .occupancy(occupancy), .full(full), .free_addr(free_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: table arrays plus expected search results {valid,hit,multi,addr}.
    logic        m_valid [16];
    logic [15:0] m_key   [16];
    logic [6:0]  exp_q [$];

    function automatic logic [6:0] model_search(input logic [15:0] key);
        int n = 0;
        int lo = 0;
        for (int i = 15; i >= 0; i--) begin
            if (m_valid[i] && m_key[i] == key) begin
                n++;
                lo = i;
            end
        end
        return {1'b1, n > 0, n > 1, 4'(lo)};
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic int model_free();
        for (int i = 0; i < 16; i++) if (!m_valid[i]) return i;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            exp_q.delete();
        end else begin
            exp_q.push_back(srch_en ? model_search(srch_key) : 7'd0);
            if (exp_q.size() > 2) void'(exp_q.pop_front());
            if (flush) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            end else begin
                if (wr_en) begin
                    m_key[wr_addr]   = wr_data;
                    m_valid[wr_addr] = 1'b1;
                end
                if (inv_en) m_valid[inv_addr] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [6:0] e;
            e = (exp_q.size() == 2) ? exp_q[0] : 7'd0;
            check("model_srch_valid", 32'(srch_valid), 32'(e[6]));
            check("model_srch_hit", 32'(srch_hit), 32'(e[5]));
            check("model_srch_multi", 32'(srch_multi), 32'(e[4]));
            check("model_srch_addr", 32'(srch_addr), 32'(e[3:0]));
            check("model_occupancy", 32'(occupancy), 32'(model_count()));
            check("model_full", 32'(full), 32'(model_count() == 16));
            check("model_free_addr", 32'(free_addr), 32'(model_free()));
        end
    end

    task automatic op(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                      input logic iv, input logic [3:0] ia, input logic f,
                      input logic s, input logic [15:0] sk);
        @(negedge clk);
        wr_en = w; wr_addr = wa; wr_data = wd;
        inv_en = iv; inv_addr = ia; flush = f;
        srch_en = s; srch_key = sk;
    endtask

    task automatic idle();
        op(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        op(1'b1, a, d, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic srch(input logic [15:0] k);
        op(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b1, k);
    endtask

    task automatic check_res(input string tag, input logic v, input logic h,
                             input logic [3:0] a, input logic m);
        check({tag, "_valid"}, 32'(srch_valid), 32'(v));
        check({tag, "_hit"}, 32'(srch_hit), 32'(h));
        check({tag, "_addr"}, 32'(srch_addr), 32'(a));
        check({tag, "_multi"}, 32'(srch_multi), 32'(m));
    endtask

    task automatic check_occ(input string tag, input int occ, input logic f, input logic [3:0] fr);
        check({tag, "_occupancy"}, 32'(occupancy), 32'(occ));
        check({tag, "_full"}, 32'(full), 32'(f));
        check({tag, "_free_addr"}, 32'(free_addr), 32'(fr));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_occ("reset", 0, 1'b0, 4'd0);
        check_res("reset", 1'b0, 1'b0, 4'd0, 1'b0);

        srch(16'h0000); idle(); idle();
        check_res("empty_search", 1'b1, 1'b0, 4'd0, 1'b0);

        wr(4'd5, 16'hBEEF); wr(4'd9, 16'hBEEF); srch(16'hBEEF); idle(); idle();
        check_res("beef_multi", 1'b1, 1'b1, 4'd5, 1'b1);
        check_occ("beef", 2, 1'b0, 4'd0);

        op(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 1'b0, 1'b1, 16'h1234);
        srch(16'h1234); idle();
        check_res("same_cycle_write", 1'b1, 1'b0, 4'd0, 1'b0);
        idle();
        check_res("next_cycle_search", 1'b1, 1'b1, 4'd3, 1'b0);

        for (int i = 0; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i));
        idle();
        check_occ("filled", 16, 1'b1, 4'd0);
        op(1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 1'b0, 1'b0, 16'd0); idle();
        check_occ("inv7", 15, 1'b0, 4'd7);
        op(1'b1, 4'd2, 16'h5555, 1'b1, 4'd2, 1'b0, 1'b0, 16'd0); idle();
        check_occ("wr_inv_same", 14, 1'b0, 4'd2);
        srch(16'h1002); idle(); idle();
        check_res("inv2_search", 1'b1, 1'b0, 4'd0, 1'b0);
        op(1'b1, 4'd7, 16'h1007, 1'b1, 4'd9, 1'b0, 1'b0, 16'd0); idle();
        check_occ("wr_inv_diff", 14, 1'b0, 4'd2);
        srch(16'h100A); idle(); idle();
        check_res("lone_hit", 1'b1, 1'b1, 4'd10, 1'b0);
        wr(4'd2, 16'h1002); wr(4'd9, 16'h1009); idle();
        check_occ("refilled", 16, 1'b1, 4'd0);

        op(1'b1, 4'd0, 16'h1000, 1'b0, 4'd0, 1'b1, 1'b0, 16'd0); idle();
        check_occ("flush", 0, 1'b0, 4'd0);
        srch(16'h1000); idle(); idle();
        check_res("post_flush", 1'b1, 1'b0, 4'd0, 1'b0);

        wr(4'd0, 16'hAAAA);
        srch(16'hAAAA);
        srch(16'hAAAA);
        #2 rst_n = 1'b0;
        #1 check_res("in_reset", 1'b0, 1'b0, 4'd0, 1'b0);
        check_occ("in_reset", 0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_res("killed", 1'b0, 1'b0, 4'd0, 1'b0);
        srch_en = 1'b1; srch_key = 16'hAAAA;
        @(negedge clk);
        check_res("first_post_reset", 1'b1, 1'b0, 4'd0, 1'b0);
        idle(); idle(); idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_table.md
# cam_table

Parametrised content-addressable match table: the next generation of the team's 16-entry CAM encoder. It stores DEPTH keys of DATA_WIDTH bits, each with a valid bit. It accepts writes, single-entry invalidates and a whole-table flush, and performs pipelined key searches. Each search returns the lowest matching index, plus a multiple-hit flag and a free-slot pointer. It sits between the lookup front end and the tag-indexed data store.

## Interface
- DATA_WIDTH, 16, key width in bits
- ADDR_WIDTH, 4, index width
- DEPTH, 1 << ADDR_WIDTH, number of entries (derived; not overridden)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- wr_en  in  1  write wr_data into entry wr_addr and set its valid bit
- wr_addr  in  ADDR_WIDTH  write index
- wr_data  in  DATA_WIDTH  key to store
- inv_en  in  1  clear valid bit of entry inv_addr
- inv_addr  in  ADDR_WIDTH  invalidate index
- flush  in  1  clear all valid bits
- srch_en  in  1  launch search of srch_key
- srch_key  in  DATA_WIDTH  search key
- srch_valid  out  1  search result valid this cycle
- srch_hit  out  1  at least one valid entry matched
- srch_addr  out  ADDR_WIDTH  lowest matching index (0 when no hit)
- srch_multi  out  1  two or more valid entries matched
- occupancy  out  ADDR_WIDTH+1  count of valid entries
- full  out  1  all DEPTH entries valid
- free_addr  out  ADDR_WIDTH  lowest invalid index (0 when full)

## Operation
- Reset (rst_n low, asynchronous):
  - all valid bits and the search pipeline clear.
  - srch_valid, srch_hit, srch_multi, srch_addr, occupancy and full are 0; free_addr is 0.
  - Key storage is not reset and is don't-care while its valid bit is 0.
- Update priority per cycle: flush > inv_en > wr_en.
  - flush: every valid bit clears; occupancy is 0 next cycle; wr_en and inv_en that cycle are ignored.
  - inv_en with wr_en to the same address: the entry ends invalid; the key storage may update.
  - inv_en with wr_en to different addresses: both take effect.
- Write to an already-valid entry overwrites the key; occupancy is unchanged.
- Invalidate of an invalid entry is a no-op.
- occupancy changes by (+1 if the write sets a new valid bit) (−1 if the invalidate clears a valid bit). Its range is 0..DEPTH; it cannot overflow.
- Match condition: entry valid AND key == srch_key, full-width equality.
- srch_addr is a priority encode of the match vector, with the lowest index winning.
- srch_multi is set when more than one bit of the match vector is set.
- full and free_addr are registered and derived from the post-update valid vector. They change one cycle after the causing update.

## Timing
- Search pipeline, 2 stages, fully pipelined; a new search is accepted every cycle.
  - Stage 1 (cycle N): srch_key is compared against the table state at the start of N. The match vector is registered at the end of N.
  - Stage 2 (cycle N+1): priority encode and multi-detect, registered.
  - Results: srch_valid, srch_hit, srch_addr and srch_multi are valid during cycle N+2.
- Writes, invalidates or flushes in cycle N or later do not affect a search launched in N; search results always reflect pre-update contents.
- When srch_valid is 0, srch_hit, srch_multi and srch_addr are 0.
- Write, invalidate and flush take effect at the clk edge ending the issuing cycle. A search issued in N+1 sees them.
- Reset asserted mid-search kills in-flight results: srch_valid is 0 and stays 0 until new searches have flowed through both stages after reset release.
- Ports have no back-pressure; every request is accepted.

## Test plan
- Reset, then search key 0x0000 -> srch_valid=1 two cycles later, srch_hit=0, srch_addr=0. Check occupancy=0, full=0, free_addr=0.
- Write 0xBEEF to entries 5 and 9, then search 0xBEEF -> srch_hit=1, srch_addr=5, srch_multi=1. Check occupancy=2 and free_addr=0.
- Write key K to entry 3 and search K in the same cycle -> result shows srch_hit=0. Search K again in the next cycle -> srch_hit=1, srch_addr=3.
- Fill all 16 entries (keys 0x1000+i) -> full=1, occupancy=16, free_addr=0. Invalidate entry 7 -> full=0, occupancy=15, free_addr=7. Write and invalidate entry 2 in the same cycle -> entry 2 ends invalid, occupancy=14.
- With 16 valid entries, assert flush together with wr_en to entry 0 -> occupancy=0 next cycle. Search 0x1000 -> srch_hit=0.
- Issue back-to-back searches on 4 consecutive cycles and pulse rst_n low during the second -> srch_valid is 0 for all in-flight results. The first post-reset search returns srch_valid=1 after 2 cycles.
